// File: rtl/div_unit_if.sv
// Handshake and data bundle between the pipeline and the multi-cycle divider.
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic        flush;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  modport master (
    output start, signed_div, flush, operand_1, operand_2,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, signed_div, flush, operand_1, operand_2,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (quotient -> LO, remainder -> HI).
// Define DIV_SIGNED_EN to add the signed (DIV) path; otherwise every op is DIVU.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvsr;
  logic [31:0] res_lo, res_hi;

  logic        accept, div_zero, last;
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] quo_step, rem_step;
  logic [31:0] fin_lo, fin_hi;
  logic [31:0] mag_1, mag_2;

  assign accept   = (state == IDLE) && bus.start && !bus.flush;
  assign div_zero = (bus.operand_2 == 32'd0);
  assign last     = (state == CALC) && (cnt == 6'd31);

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  logic neg_1, neg_2;

  assign neg_1 = bus.signed_div & bus.operand_1[31];
  assign neg_2 = bus.signed_div & bus.operand_2[31];
  assign mag_1 = neg_1 ? -bus.operand_1 : bus.operand_1;
  assign mag_2 = neg_2 ? -bus.operand_2 : bus.operand_2;
  // Quotient takes the XOR of signs, remainder follows the dividend.
  assign fin_lo = neg_q ? -quo_step : quo_step;
  assign fin_hi = neg_r ? -rem_step : rem_step;
`else
  logic unused_signed_div;

  assign unused_signed_div = bus.signed_div;
  assign mag_1  = bus.operand_1;
  assign mag_2  = bus.operand_2;
  assign fin_lo = quo_step;
  assign fin_hi = rem_step;
`endif

  // quo doubles as the dividend shift register: dividend bits leave the top
  // while quotient bits enter the bottom.
  always_comb begin
    trial    = {rem, quo[31]} - {1'b0, dvsr};
    qbit     = ~trial[32];
    rem_step = qbit ? trial[31:0] : {rem[30:0], quo[31]};
    quo_step = {quo[30:0], qbit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = div_zero ? DONE : CALC;
        CALC:    if (cnt == 6'd31) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      res_lo <= '0;
      res_hi <= '0;
`ifdef DIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
      if (div_zero) begin
        res_lo <= '1;
        res_hi <= bus.operand_1;
      end else begin
        quo  <= mag_1;
        rem  <= '0;
        dvsr <= mag_2;
`ifdef DIV_SIGNED_EN
        neg_q <= neg_1 ^ neg_2;
        neg_r <= neg_1;
`endif
      end
    end else if (state == CALC && !bus.flush) begin
      cnt <= cnt + 6'd1;
      quo <= quo_step;
      rem <= rem_step;
      if (last) begin
        res_lo <= fin_lo;
        res_hi <= fin_hi;
      end
    end
  end

  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expectations follow DIV_SIGNED_EN.
module tb_div_unit;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits 1ns after a rising edge; returns 1ns after the sampling edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.operand_1  = a;
    bus.operand_2  = b;
    bus.signed_div = s;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  // Latency in cycles after the sampling edge; 60 means the wait expired.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result_lo !== 32'd0 || bus.result_hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state busy=%b done=%b lo=%h hi=%h, want 0 0 0 0",
               bus.busy, bus.done, bus.result_lo, bus.result_hi);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    bit busy_ok;
    start_op(32'd100, 32'd7, 1'b0);
    busy_ok = 1'b1;
    lat = 1;
    while (!bus.done && lat < 60) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat != 33) begin
      tests_failed++;
      $display("FAIL udiv_latency got %0d want 33", lat);
    end
    tests_run++;
    if (!busy_ok || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL udiv_busy busy dropped during op (now %b) want 1", bus.busy);
    end
    tests_run++;
    if (bus.result_lo !== 32'd14 || bus.result_hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL udiv_result lo=%0d hi=%0d want 14 2", bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL udiv_done_pulse done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] exp_lo, exp_hi;
`ifdef DIV_SIGNED_EN
    exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
    exp_lo = 32'h7FFF_FFFC; exp_hi = 32'h0000_0001;
`endif
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat);
    tests_run++;
    if (lat != 33 || bus.result_lo !== exp_lo || bus.result_hi !== exp_hi) begin
      tests_failed++;
      $display("FAIL sdiv_neg lat=%0d lo=%h hi=%h want 33 %h %h", lat, bus.result_lo, bus.result_hi, exp_lo, exp_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(32'h0000_1234, 32'd0, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat != 1 || bus.result_lo !== 32'hFFFF_FFFF || bus.result_hi !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL div_zero lat=%0d lo=%h hi=%h want 1 ffffffff 00001234", lat, bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] exp_lo, exp_hi;
`ifdef DIV_SIGNED_EN
    exp_lo = 32'h8000_0000; exp_hi = 32'h0000_0000;
`else
    exp_lo = 32'h0000_0000; exp_hi = 32'h8000_0000;
`endif
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    tests_run++;
    if (lat != 33 || bus.result_lo !== exp_lo || bus.result_hi !== exp_hi) begin
      tests_failed++;
      $display("FAIL overflow lat=%0d lo=%h hi=%h want 33 %h %h", lat, bus.result_lo, bus.result_hi, exp_lo, exp_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    bus.operand_1 = 32'd1;
    bus.operand_2 = 32'd1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    wait_done(lat);
    tests_run++;
    if (bus.result_lo !== 32'd14 || bus.result_hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL ignore_start lo=%0d hi=%0d want 14 2", bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat;
    bit saw_done;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    saw_done = 1'b0;
    repeat (40) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++;
    if (saw_done || bus.result_lo !== 32'd14 || bus.result_hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL flush_hold done_seen=%b lo=%0d hi=%0d want 0 14 2", saw_done, bus.result_lo, bus.result_hi);
    end
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat != 33 || bus.result_lo !== 32'd3 || bus.result_hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL after_flush lat=%0d lo=%0d hi=%0d want 33 3 0", lat, bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result_lo !== 32'd0 || bus.result_hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid busy=%b done=%b lo=%h hi=%h want 0 0 0 0",
               bus.busy, bus.done, bus.result_lo, bus.result_hi);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    saw_done = 1'b0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++;
      $display("FAIL reset_abandon activity after reset got 1 want 0");
    end
  endtask

  task automatic test_start_flush();
    bus.operand_1 = 32'd50;
    bus.operand_2 = 32'd5;
    bus.start     = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result_lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL start_flush busy=%b done=%b lo=%0d want 0 0 0", bus.busy, bus.done, bus.result_lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'd20, 32'd6, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat != 33 || bus.result_lo !== 32'd3 || bus.result_hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL b2b_first lat=%0d lo=%0d hi=%0d want 33 3 2", lat, bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
    start_op(32'd50, 32'd7, 1'b0);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept busy=%b want 1", bus.busy);
    end
    wait_done(lat);
    tests_run++;
    if (lat != 33 || bus.result_lo !== 32'd7 || bus.result_hi !== 32'd1) begin
      tests_failed++;
      $display("FAIL b2b_second lat=%0d lo=%0d hi=%0d want 33 7 1", lat, bus.result_lo, bus.result_hi);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.signed_div = 1'b0;
    bus.operand_1  = '0;
    bus.operand_2  = '0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    test_start_flush();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division of operand_1 by operand_2; sampled only in IDLE.
REQ-004 SHALL have port signed_div, input, 1 bit: 1 selects signed (DIV), 0 selects unsigned (DIVU); sampled with start.
REQ-005 SHALL have port flush, input, 1 bit: pipeline annul; aborts any operation in progress.
REQ-006 SHALL have port operand_1, input, 32 bits: dividend, as delivered by the ID-stage operand generator.
REQ-007 SHALL have port operand_2, input, 32 bits: divisor.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE; the pipeline stalls on busy & !done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking results valid.
REQ-010 SHALL have port result_lo, output, 32 bits: quotient (LO).
REQ-011 SHALL have port result_hi, output, 32 bits: remainder (HI).

Function
REQ-012 SHALL implement the states IDLE, CALC and DONE as a registered FSM.
REQ-013 SHALL, in IDLE with start=1, flush=0 and operand_2!=0, latch both operands and signed_div, clear the iteration counter, and go to CALC.
REQ-014 SHALL, in IDLE with start=1, flush=0 and operand_2==0, go directly to DONE with quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-015 SHALL perform radix-2 restoring division in CALC, one quotient bit per cycle, using a 6-bit counter running 0..31 and a 33-bit partial-remainder subtract.
REQ-016 SHALL go from CALC to DONE after exactly 32 iteration cycles, so done is high on the 33rd cycle after start is sampled.
REQ-017 SHALL, for signed operations, divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-018 SHALL produce quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF, with no trap or flag.
REQ-019 SHALL, in DONE, assert done for exactly one cycle with results valid, then return to IDLE.
REQ-020 SHALL keep result_lo and result_hi registered and hold them unchanged until the next accepted start.
REQ-021 SHALL ignore start in CALC and DONE; the latched operands are unaffected.
REQ-022 SHALL treat flush=1 in any state as a return to IDLE on the next edge, with done not asserted and results unchanged.
REQ-023 SHALL give flush priority over start when both are asserted in the same cycle: the request is not accepted.
REQ-024 SHALL accept a new start in the cycle immediately after DONE (back-to-back operation).

Reset
REQ-025 SHALL, while rst=0 and independent of clk, force state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, counter=0 and clear all internal operand registers.
REQ-026 SHALL, on reset assertion mid-CALC, abandon the operation; done SHALL NOT be asserted afterwards for that operation.

Configuration
REQ-027 SHALL, with DIV_SIGNED_EN defined, implement the signed path of REQ-017 and REQ-018.
REQ-028 SHALL, without DIV_SIGNED_EN, ignore signed_div, treat every operation as unsigned, and omit the sign/negate logic; latency is unchanged.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> done after 33 cycles, lo=14, hi=2, busy high from the cycle after start through the done cycle.
REQ-030 SHALL cover: signed 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; the same case without DIV_SIGNED_EN -> lo=0x7FFFFFFC, hi=1.
REQ-031 SHALL cover: 0x1234/0 -> done on the next cycle, lo=0xFFFFFFFF, hi=0x1234.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL cover: flush 10 cycles after start -> busy low on the next cycle, no done, results unchanged; then 9/3 -> lo=3, hi=0.
REQ-034 SHALL cover: rst=0 at counter=15 -> all outputs 0 immediately; start and flush together in IDLE -> request ignored, busy stays 0.
